// File: rtl/m31_adder_arbiter.sv
// m31_adder_arbiter
//   Shares one external combinational M31 adder ((a+b) mod 2^31-1) between
//   NUM_REQ requesters. A round-robin arbiter picks one requester per cycle.
//   The granted operands enter a two-stage pipeline:
//     stage 1 - operand register, which drives the external adder;
//     stage 2 - result register, which captures the adder sum.
//   Each operation carries the index of its requester. The result is returned
//   on that requester's response channel.
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   rst_n      in   synchronous active-low reset
//   req_valid  in   [NUM_REQ]             per-requester request valid
//   req_ready  out  [NUM_REQ]             per-requester accept (at most one high)
//   req_a      in   [NUM_REQ*DATA_WIDTH]  operand a, requester i at [i*DW +: DW]
//   req_b      in   [NUM_REQ*DATA_WIDTH]  operand b, same packing
//   rsp_valid  out  [NUM_REQ]             per-requester result valid (at most one high)
//   rsp_ready  in   [NUM_REQ]             per-requester result accept
//   rsp_data   out  [DATA_WIDTH]          shared result bus
//   add_a      out  [DATA_WIDTH]          stage-1 operand a to the adder
//   add_b      out  [DATA_WIDTH]          stage-1 operand b to the adder
//   add_sum    in   [DATA_WIDTH]          reduced sum returned by the adder
//   busy       out                        any pipeline stage occupied
module m31_adder_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 31
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [DATA_WIDTH-1:0]         add_a,
  output logic [DATA_WIDTH-1:0]         add_b,
  input  logic [DATA_WIDTH-1:0]         add_sum,
  output logic                          busy
);

  localparam int TAG_W = $clog2(NUM_REQ);

  logic [TAG_W-1:0]      rr_ptr_q,  rr_ptr_d;
  logic                  s1_vld_q,  s1_vld_d;
  logic [DATA_WIDTH-1:0] s1_a_q,    s1_a_d;
  logic [DATA_WIDTH-1:0] s1_b_q,    s1_b_d;
  logic [TAG_W-1:0]      s1_tag_q,  s1_tag_d;
  logic                  s2_vld_q,  s2_vld_d;
  logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
  logic [TAG_W-1:0]      s2_tag_q,  s2_tag_d;

  logic             grant_found;
  logic [TAG_W-1:0] grant_idx;
  logic             req_fire;
  logic             rsp_fire;
  logic             s1_move;
  logic             s1_can_load;
  logic             s2_can_load;

  // Round-robin search starting at rr_ptr. The loop runs from the farthest
  // offset down to offset 0, so the last match written is the nearest one.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = TAG_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // Pipeline flow control. Stage 2 frees up in the same cycle its result is
  // accepted, which lets a full pipe advance one operation per cycle.
  always_comb begin
    rsp_fire    = s2_vld_q && rsp_ready[s2_tag_q];
    s2_can_load = !s2_vld_q || rsp_fire;
    s1_can_load = !s1_vld_q || s2_can_load;
    s1_move     = s1_vld_q && s2_can_load;
    req_fire    = rst_n && grant_found && s1_can_load;
  end

  // Only the granted requester sees ready. The grant is masked while reset is
  // asserted so that no request appears accepted during reset.
  always_comb begin
    req_ready = '0;
    if (req_fire) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = s2_vld_q && (s2_tag_q == TAG_W'(i));
    end
  end

  assign rsp_data = s2_data_q;
  assign add_a    = s1_a_q;
  assign add_b    = s1_b_q;
  assign busy     = s1_vld_q || s2_vld_q;

  // Next-state logic. A new request overrides the "stage 1 drains" case.
  // A stage 1 -> stage 2 move overrides the "stage 2 drains" case.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    s1_vld_d  = s1_vld_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_tag_d  = s1_tag_q;
    s2_vld_d  = s2_vld_q;
    s2_data_d = s2_data_q;
    s2_tag_d  = s2_tag_q;

    if (req_fire) begin
      s1_vld_d = 1'b1;
      s1_a_d   = req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      s1_b_d   = req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      s1_tag_d = grant_idx;
      rr_ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (s1_move) begin
      s1_vld_d = 1'b0;
    end

    if (s1_move) begin
      s2_vld_d  = 1'b1;
      s2_data_d = add_sum;
      s2_tag_d  = s1_tag_q;
    end else if (rsp_fire) begin
      s2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_tag_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_tag_q  <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      s1_vld_q  <= s1_vld_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_tag_q  <= s1_tag_d;
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
      s2_tag_q  <= s2_tag_d;
    end
  end

endmodule

// File: tb/tb_m31_adder_arbiter.sv
// tb_m31_adder_arbiter
//   Scoreboard bench for m31_adder_arbiter. The bench provides the external
//   M31 adder, and a driver feeds per-requester operation lists. Each
//   operation's hand-computed result is pushed when its request is accepted.
//   A separate monitor pops the scoreboard on every response handshake.
module tb_m31_adder_arbiter;

  localparam int N  = 4;
  localparam int DW = 31;

  typedef struct packed {
    logic [30:0] a;
    logic [30:0] b;
    logic [30:0] e;
  } op_t;

  typedef struct packed {
    logic [1:0]  tag;
    logic [30:0] d;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic [DW-1:0]   add_a;
  logic [DW-1:0]   add_b;
  logic [DW-1:0]   add_sum;
  logic            busy;

  op_t  ops [N][32];
  int   head [N];
  int   tail [N];
  exp_t sb[$];
  int   grant_exp[$];
  int   fire_log[$];
  int   rsp_log[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_fire_cyc = 0;

  m31_adder_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .busy      (busy)
  );

  // The external adder the block is meant to share.
  assign add_sum = 31'((32'(add_a) + 32'(add_b)) % 32'h7FFF_FFFF);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input int r, input logic [30:0] a, input logic [30:0] b,
                               input logic [30:0] e);
    op_t o;
    o.a = a;
    o.b = b;
    o.e = e;
    ops[r][tail[r] % 32] = o;
    tail[r]++;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic waitIdle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      stepCycle();
      done = (sb.size() == 0) && (grant_exp.size() == 0) && !busy && (req_valid == '0);
      for (int i = 0; i < N; i++) if (head[i] != tail[i]) done = 1'b0;
    end
    checkOutput(name, {31'd0, done}, 32'd1);
  endtask

  // Two results per requester, hand-reduced mod 2^31-1.
  task automatic loadRoundRobin();
    applyStimulus(0, 31'd1,          31'd2,          31'd3);
    applyStimulus(1, 31'h7FFF_FFFE, 31'd1,          31'd0);
    applyStimulus(2, 31'd0,          31'd0,          31'd0);
    applyStimulus(3, 31'h7FFF_FFF0, 31'h20,         31'h11);
    applyStimulus(0, 31'h7FFF_FFFE, 31'h7FFF_FFFE, 31'h7FFF_FFFD);
    applyStimulus(1, 31'h4000_0000, 31'h4000_0000, 31'd1);
    applyStimulus(2, 31'h1234_5678, 31'h1111_1111, 31'h2345_6789);
    applyStimulus(3, 31'd100,        31'd200,        31'd300);
  endtask

  // Driver: records accepted requests, pushes their expectations, and then
  // presents each requester's next operation.
  initial begin
    logic [N-1:0] fire_v;
    exp_t x;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    forever begin
      @(negedge clk);
      fire_v = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire_v[i]) begin
          if (grant_exp.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL grant: got requester %0d, expected no grant", i);
          end else begin
            checkOutput("grant", i, grant_exp.pop_front());
          end
          x.tag = 2'(i);
          x.d = ops[i][head[i] % 32].e;
          sb.push_back(x);
          head[i]++;
          fire_log.push_back(cyc);
          last_fire_cyc = cyc;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (head[i] != tail[i]) begin
          req_valid[i] = 1'b1;
          req_a[i*DW +: DW] = ops[i][head[i] % 32].a;
          req_b[i*DW +: DW] = ops[i][head[i] % 32].b;
        end else begin
          req_valid[i] = 1'b0;
          req_a[i*DW +: DW] = '0;
          req_b[i*DW +: DW] = '0;
        end
      end
    end
  end

  // Monitor: one-hot checks, hold-stability checks, and a scoreboard pop on
  // each response handshake.
  initial begin
    bit hold_prev;
    logic [DW-1:0] prev_data;
    exp_t x;
    int tag;
    hold_prev = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (req_ready != '0) checkOutput("req_ready_onehot", $countones(req_ready), 1);
      if (rsp_valid != '0) begin
        checkOutput("rsp_valid_onehot", $countones(rsp_valid), 1);
        if (hold_prev) checkOutput("rsp_data_stable", {1'b0, rsp_data}, {1'b0, prev_data});
      end
      if (rst_n && ((rsp_valid & rsp_ready) != '0)) begin
        tag = 0;
        for (int i = 0; i < N; i++) if (rsp_valid[i] && rsp_ready[i]) tag = i;
        rsp_log.push_back(cyc);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL rsp_unexpected: got tag %0d data 0x%0h, expected none", tag, rsp_data);
        end else begin
          x = sb.pop_front();
          checkOutput("rsp_tag", tag, {30'd0, x.tag});
          checkOutput("rsp_data", {1'b0, rsp_data}, {1'b0, x.d});
        end
      end
      hold_prev = rst_n && (rsp_valid != '0) && ((rsp_valid & rsp_ready) == '0);
      prev_data = rsp_data;
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    rst_n = 1'b0;
    rsp_ready = '0;

    // Reset with every requester asking.
    loadRoundRobin();
    repeat (3) stepCycle();
    checkOutput("reset_req_valid_all", {28'd0, req_valid}, 32'hF);
    checkOutput("reset_req_ready", {28'd0, req_ready}, 32'h0);
    checkOutput("reset_rsp_valid", {28'd0, rsp_valid}, 32'h0);
    checkOutput("reset_busy", {31'd0, busy}, 32'h0);
    checkOutput("reset_rsp_data", {1'b0, rsp_data}, 32'h0);
    checkOutput("reset_add_a", {1'b0, add_a}, 32'h0);
    checkOutput("reset_add_b", {1'b0, add_b}, 32'h0);

    // Round robin starting at 0, one grant per cycle.
    for (int k = 0; k < 8; k++) grant_exp.push_back(k % 4);
    fire_log.delete();
    rsp_ready = 4'hF;
    rst_n = 1'b1;
    waitIdle("rr_idle", 60);
    checkOutput("rr_fire_count", fire_log.size(), 8);
    if (fire_log.size() == 8) checkOutput("rr_throughput", fire_log[7] - fire_log[0], 7);

    // Requester 2 silent: it is skipped without a bubble.
    fire_log.delete();
    applyStimulus(0, 31'd5,          31'd6,          31'd11);
    applyStimulus(1, 31'd7,          31'd8,          31'd15);
    applyStimulus(3, 31'h5555_5555, 31'h2AAA_AAAA, 31'd0);
    applyStimulus(0, 31'h3FFF_FFFF, 31'h4000_0000, 31'd0);
    applyStimulus(1, 31'h7FFF_FFFD, 31'd3,          31'd1);
    applyStimulus(3, 31'h10,         31'h7FFF_FFF0, 31'd1);
    grant_exp.push_back(0); grant_exp.push_back(1); grant_exp.push_back(3);
    grant_exp.push_back(0); grant_exp.push_back(1); grant_exp.push_back(3);
    waitIdle("skip_idle", 60);
    checkOutput("skip_fire_count", fire_log.size(), 6);
    if (fire_log.size() == 6) checkOutput("skip_no_bubble", fire_log[5] - fire_log[0], 5);

    // Single op on requester 1, with a latency check.
    applyStimulus(1, 31'h7FFF_FFFE, 31'd1, 31'd0);
    grant_exp.push_back(1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) break;
    end
    checkOutput("single_rsp_valid", {28'd0, rsp_valid}, 32'h2);
    checkOutput("single_latency", cyc - last_fire_cyc, 1);
    waitIdle("single_idle", 20);
    applyStimulus(1, 31'h7FFF_FFFE, 31'h7FFF_FFFE, 31'h7FFF_FFFD);
    grant_exp.push_back(1);
    waitIdle("single2_idle", 20);

    // Backpressure: pointer is at 2, so grants are 2,3 and then 0 waits.
    rsp_ready = '0;
    applyStimulus(2, 31'd10,         31'd20, 31'd30);
    applyStimulus(0, 31'h7FFF_FFFE, 31'd2,  31'd1);
    applyStimulus(3, 31'd3,          31'd4,  31'd7);
    grant_exp.push_back(2); grant_exp.push_back(3); grant_exp.push_back(0);
    repeat (5) stepCycle();
    checkOutput("bp_req_ready", {28'd0, req_ready}, 32'h0);
    checkOutput("bp_busy", {31'd0, busy}, 32'h1);
    checkOutput("bp_rsp_valid", {28'd0, rsp_valid}, 32'h4);
    checkOutput("bp_rsp_data", {1'b0, rsp_data}, 32'd30);
    checkOutput("bp_add_a", {1'b0, add_a}, 32'd3);
    rsp_log.delete();
    rsp_ready = 4'hF;
    waitIdle("bp_idle", 30);
    checkOutput("bp_drain_count", rsp_log.size(), 3);
    if (rsp_log.size() == 3) checkOutput("bp_drain_rate", rsp_log[1] - rsp_log[0], 1);

    // Flow-through with intermittent response backpressure; pointer is at 1.
    loadRoundRobin();
    for (int k = 0; k < 8; k++) grant_exp.push_back((k + 1) % 4);
    for (int k = 0; k < 30; k++) begin
      rsp_ready = ((8'b1011_0110 >> (k % 8)) & 8'd1) != 8'd0 ? 4'hF : 4'h0;
      stepCycle();
    end
    rsp_ready = 4'hF;
    waitIdle("flow_idle", 40);

    // Reset with both stages full; pointer is at 1, so grants are 1 then 0.
    rsp_ready = '0;
    applyStimulus(0, 31'h100, 31'h200, 31'h300);
    applyStimulus(1, 31'h7FFF_FFFE, 31'h5, 31'h4);
    grant_exp.push_back(1); grant_exp.push_back(0);
    repeat (4) stepCycle();
    checkOutput("midrst_busy_before", {31'd0, busy}, 32'h1);
    checkOutput("midrst_rsp_before", {28'd0, rsp_valid}, 32'h2);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) head[i] = tail[i];
    sb.delete();
    grant_exp.delete();
    stepCycle();
    checkOutput("midrst_busy", {31'd0, busy}, 32'h0);
    checkOutput("midrst_rsp_valid", {28'd0, rsp_valid}, 32'h0);
    checkOutput("midrst_add_a", {1'b0, add_a}, 32'h0);
    stepCycle();
    rst_n = 1'b1;
    rsp_ready = 4'hF;
    applyStimulus(3, 31'd1, 31'd1, 31'd2);
    applyStimulus(0, 31'd9, 31'd9, 31'd18);
    grant_exp.push_back(0); grant_exp.push_back(3);
    waitIdle("midrst_idle", 30);
    repeat (3) stepCycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
